half_adder: RTL and testbench

- Single-bit-per-lane half adder: sum = a XOR b, carry = a AND b.
- Outputs are provided in two forms: combinational (zero latency) and registered (one-cycle latency, with a valid flag).
- A saturating carry-event counter supports datapath monitoring.
- Used as a leaf arithmetic primitive feeding full adders and counters elsewhere in the design.

---
 rtl/half_adder.sv | 71 +++++++
 tb/tb_half_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Multi-lane half adder with combinational and registered outputs, plus a
// saturating counter of valid cycles in which any lane produced a carry.
module half_adder #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic             valid_d;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Zero-latency path; deliberately untouched by clk and rst_n.
    always_comb begin
        sum   = a ^ b;
        carry = a & b;
    end

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sum;
            carry_d = carry;
        end
    end

    // One increment per carrying cycle no matter how many lanes carry; clear wins.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (in_valid && (|carry) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench: a 4-lane/16-bit-counter instance and a 1-lane/2-bit-counter
// instance, checked against an arithmetic reference model.
module tb_half_adder;

    logic clk;
    logic rst_n;

    logic [3:0]  a_a, b_a, sum_a, carry_a, sum_q_a, carry_q_a;
    logic        inv_a, clr_a, ov_a;
    logic [15:0] cnt_a;

    logic [0:0]  a_b, b_b, sum_b, carry_b, sum_q_b, carry_q_b;
    logic        inv_b, clr_b, ov_b;
    logic [1:0]  cnt_b;

    int unsigned checks;
    int unsigned failures;

    // Reference model state
    logic [3:0]  m_sum_a, m_carry_a;
    logic        m_ov_a;
    int unsigned m_cnt_a;
    logic        m_sum_b, m_carry_b, m_ov_b;
    int unsigned m_cnt_b;

    half_adder #(.WIDTH(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .a(a_a), .b(b_a), .in_valid(inv_a), .cnt_clr(clr_a),
        .sum(sum_a), .carry(carry_a), .sum_q(sum_q_a), .carry_q(carry_q_a),
        .out_valid(ov_a), .carry_cnt(cnt_a)
    );

    half_adder #(.WIDTH(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .a(a_b), .b(b_b), .in_valid(inv_b), .cnt_clr(clr_b),
        .sum(sum_b), .carry(carry_b), .sum_q(sum_q_b), .carry_q(carry_q_b),
        .out_valid(ov_b), .carry_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-lane arithmetic add; result is {carry[3:0], sum[3:0]}.
    function automatic logic [7:0] ref_add(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] s, c;
        for (int i = 0; i < 4; i++) begin
            int unsigned t;
            t    = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sum_a = '0; m_carry_a = '0; m_ov_a = 1'b0; m_cnt_a = 0;
        m_sum_b = 1'b0; m_carry_b = 1'b0; m_ov_b = 1'b0; m_cnt_b = 0;
    endtask

    task automatic model_edge();
        logic [7:0] ra, rb;
        ra = ref_add(a_a, b_a);
        rb = ref_add({3'b000, a_b}, {3'b000, b_b});
        m_ov_a = inv_a;
        if (inv_a) begin m_sum_a = ra[3:0]; m_carry_a = ra[7:4]; end
        if (clr_a) m_cnt_a = 0;
        else if (inv_a && ra[7:4] != 0 && m_cnt_a < 65535) m_cnt_a++;
        m_ov_b = inv_b;
        if (inv_b) begin m_sum_b = rb[0]; m_carry_b = rb[4]; end
        if (clr_b) m_cnt_b = 0;
        else if (inv_b && rb[4] && m_cnt_b < 3) m_cnt_b++;
    endtask

    task automatic check_comb();
        logic [7:0] ra, rb;
        ra = ref_add(a_a, b_a);
        rb = ref_add({3'b000, a_b}, {3'b000, b_b});
        check("sum_a", 32'(sum_a), 32'(ra[3:0]));
        check("carry_a", 32'(carry_a), 32'(ra[7:4]));
        check("sum_b", 32'(sum_b), 32'(rb[0]));
        check("carry_b", 32'(carry_b), 32'(rb[4]));
    endtask

    task automatic check_regs();
        check("sum_q_a", 32'(sum_q_a), 32'(m_sum_a));
        check("carry_q_a", 32'(carry_q_a), 32'(m_carry_a));
        check("out_valid_a", 32'(ov_a), 32'(m_ov_a));
        check("carry_cnt_a", 32'(cnt_a), m_cnt_a);
        check("sum_q_b", 32'(sum_q_b), 32'(m_sum_b));
        check("carry_q_b", 32'(carry_q_b), 32'(m_carry_b));
        check("out_valid_b", 32'(ov_b), 32'(m_ov_b));
        check("carry_cnt_b", 32'(cnt_b), m_cnt_b);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_regs();
    endtask

    initial begin
        int unsigned cnt_before;
        logic [1:0] ab;
        logic [1:0] sat_seq [5];
        checks = 0; failures = 0;
        sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

        // Asynchronous reset with no clock edge yet
        rst_n = 1'b1;
        a_a = 4'h3; b_a = 4'h5; inv_a = 1'b0; clr_a = 1'b0;
        a_b = 1'b1; b_b = 1'b1; inv_b = 1'b0; clr_b = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_comb();
        inv_a = 1'b1; inv_b = 1'b1;
        step();
        step();
        check("reset_hold_ov_a", 32'(ov_a), 32'd0);
        rst_n = 1'b1;
        inv_a = 1'b0; inv_b = 1'b0;
        step();

        // WIDTH=1 truth table, each pattern held 100 ns
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a_b = ab[1]; b_b = ab[0];
            #1;
            check_comb();
            check("tt_sum", 32'(sum_b), 32'((i == 1) || (i == 2)));
            check("tt_carry", 32'(carry_b), 32'(i == 3));
            repeat (10) step();
        end

        // Registered path: valid 1+1, then invalid 0+1 holds results
        a_b = 1'b1; b_b = 1'b1; inv_b = 1'b1;
        step();
        check("reg_sum_q", 32'(sum_q_b), 32'd0);
        check("reg_carry_q", 32'(carry_q_b), 32'd1);
        check("reg_ov", 32'(ov_b), 32'd1);
        a_b = 1'b0; b_b = 1'b1; inv_b = 1'b0;
        step();
        check("hold_ov", 32'(ov_b), 32'd0);
        check("hold_sum_q", 32'(sum_q_b), 32'd0);
        check("hold_carry_q", 32'(carry_q_b), 32'd1);

        // CNT_W=2 saturation, then clear beating a simultaneous carry
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        a_b = 1'b1; b_b = 1'b1; inv_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_seq", 32'(cnt_b), 32'(sat_seq[i]));
        end
        clr_b = 1'b1;
        step();
        check("clr_priority", 32'(cnt_b), 32'd0);
        clr_b = 1'b0; inv_b = 1'b0;

        // WIDTH=4 directed: multiple carrying lanes count once
        a_a = 4'b1100; b_a = 4'b1010; inv_a = 1'b1;
        #1;
        check("w4_sum", 32'(sum_a), 32'h6);
        check("w4_carry", 32'(carry_a), 32'h8);
        cnt_before = 32'(cnt_a);
        step();
        check("w4_cnt_inc", 32'(cnt_a), cnt_before + 1);
        a_a = 4'b1111; b_a = 4'b1111;
        step();
        check("w4_cnt_all_lanes", 32'(cnt_a), cnt_before + 2);

        // Reset mid-operation with out_valid=1 and carry_cnt=5
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        repeat (5) step();
        check("pre_rst_cnt", 32'(cnt_a), 32'd5);
        check("pre_rst_ov", 32'(ov_a), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_cnt", 32'(cnt_a), 32'd0);
        check("mid_rst_ov", 32'(ov_a), 32'd0);
        check("mid_rst_carry_q", 32'(carry_q_a), 32'd0);
        a_a = 4'b0101; b_a = 4'b0011;
        #1;
        check_comb();
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            a_a = 4'($urandom); b_a = 4'($urandom);
            inv_a = 1'($urandom); clr_a = ($urandom_range(0, 15) == 0);
            a_b = 1'($urandom); b_b = 1'($urandom);
            inv_b = 1'($urandom); clr_b = ($urandom_range(0, 15) == 0);
            #1;
            check_comb();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
